frog_game_ctrl: RTL and testbench



---
 rtl/frog_game_pkg.sv | 23 ++
 rtl/frog_game_ctrl_if.sv | 30 +++
 rtl/frog_game_ctrl_btn_sync_edge.sv | 23 ++
 rtl/frog_game_ctrl.sv | 113 +++++++++++
 tb/tb_frog_game_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/frog_game_pkg.sv
// Shared state codes and default tuning constants for the frog game flow.
package frog_game_pkg;

   localparam logic [2:0] ST_CODE_ATTRACT = 3'd0;
   localparam logic [2:0] ST_CODE_PLAY    = 3'd1;
   localparam logic [2:0] ST_CODE_DYING   = 3'd2;
   localparam logic [2:0] ST_CODE_GOAL    = 3'd3;
   localparam logic [2:0] ST_CODE_OVER    = 3'd4;

   typedef enum logic [2:0] {
      ST_ATTRACT = ST_CODE_ATTRACT,
      ST_PLAY    = ST_CODE_PLAY,
      ST_DYING   = ST_CODE_DYING,
      ST_GOAL    = ST_CODE_GOAL,
      ST_OVER    = ST_CODE_OVER
   } game_state_t;

   localparam int DEF_LIVES        = 3;
   localparam int DEF_DEATH_FRAMES = 60;
   localparam int DEF_WIN_FRAMES   = 30;
   localparam int DEF_WIN_Y        = 20;

endpackage

// File: rtl/frog_game_ctrl_if.sv
// Signal bundle between the game-flow sequencer and the rest of the frog game.
interface frog_game_ctrl_if #(
   parameter int LIVES_W = 2,
   parameter int SCORE_W = 8
);
   logic               i_ani_stb;
   logic               i_start_btn;
   logic               i_collide;
   logic [11:0]        i_frog_y1;
   logic               o_frog_animate;
   logic               o_dead;
   logic               o_obst_animate;
   logic               o_flash;
   logic [LIVES_W-1:0] o_lives;
   logic [SCORE_W-1:0] o_score;
   logic [2:0]         o_state;
   logic               o_game_over;

   modport master (
      input  i_ani_stb, i_start_btn, i_collide, i_frog_y1,
      output o_frog_animate, o_dead, o_obst_animate, o_flash,
             o_lives, o_score, o_state, o_game_over
   );

   modport slave (
      output i_ani_stb, i_start_btn, i_collide, i_frog_y1,
      input  o_frog_animate, o_dead, o_obst_animate, o_flash,
             o_lives, o_score, o_state, o_game_over
   );
endinterface

// File: rtl/frog_game_ctrl_btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button followed by a rising-edge
// detector; a held button yields a single one-cycle pulse.
module btn_sync_edge (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_pulse
);
   logic [1:0] sync_q;
   logic       prev_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q <= 2'b00;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], i_btn};
         prev_q <= sync_q[1];
      end
   end

   assign o_pulse = sync_q[1] & ~prev_q;
endmodule

// File: rtl/frog_game_ctrl.sv
// Game-flow sequencer: attract/play/dying/goal/over, lives, score and hold
// timers, with registered decode of the frog and obstacle control signals.
module frog_game_ctrl
   import frog_game_pkg::*;
#(
   parameter int LIVES        = DEF_LIVES,
   parameter int LIVES_W      = 2,
   parameter int SCORE_W      = 8,
   parameter int TIMER_W      = 8,
   parameter int DEATH_FRAMES = DEF_DEATH_FRAMES,
   parameter int WIN_FRAMES   = DEF_WIN_FRAMES,
   parameter int WIN_Y        = DEF_WIN_Y
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   frog_game_ctrl_if.master     bus
);
   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
   localparam logic [TIMER_W-1:0] DEATH_INIT = TIMER_W'(DEATH_FRAMES - 1);
   localparam logic [TIMER_W-1:0] WIN_INIT   = TIMER_W'(WIN_FRAMES - 1);
   localparam logic [11:0]        WIN_ROW    = 12'(WIN_Y);

   game_state_t        state_q, state_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               frog_anim_q, dead_q, obst_anim_q, flash_q, over_q;
   logic               start_pulse;

   btn_sync_edge u_start_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_btn   (bus.i_start_btn),
      .o_pulse (start_pulse)
   );

   // Game events only advance on animation strobes; only start works off-strobe.
   always_comb begin
      state_d = state_q;
      lives_d = lives_q;
      score_d = score_q;
      timer_d = timer_q;
      unique case (state_q)
         ST_ATTRACT, ST_OVER: begin
            if (start_pulse) begin
               state_d = ST_PLAY;
               lives_d = LIVES_INIT;
               score_d = '0;
            end
         end
         ST_PLAY: begin
            if (bus.i_ani_stb) begin
               if (bus.i_collide) begin
                  state_d = ST_DYING;
                  lives_d = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
                  timer_d = DEATH_INIT;
               end else if (bus.i_frog_y1 <= WIN_ROW) begin
                  state_d = ST_GOAL;
                  score_d = (&score_q) ? score_q : score_q + SCORE_W'(1);
                  timer_d = WIN_INIT;
               end
            end
         end
         ST_DYING: begin
            if (bus.i_ani_stb) begin
               if (timer_q == '0) state_d = (lives_q == '0) ? ST_OVER : ST_PLAY;
               else               timer_d = timer_q - TIMER_W'(1);
            end
         end
         ST_GOAL: begin
            if (bus.i_ani_stb) begin
               if (timer_q == '0) state_d = ST_PLAY;
               else               timer_d = timer_q - TIMER_W'(1);
            end
         end
         default: state_d = ST_ATTRACT;
      endcase
   end

   // Outputs are decoded from next-state so they line up with the state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_ATTRACT;
         lives_q     <= LIVES_INIT;
         score_q     <= '0;
         timer_q     <= '0;
         frog_anim_q <= 1'b1;
         dead_q      <= 1'b1;
         obst_anim_q <= 1'b1;
         flash_q     <= 1'b0;
         over_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lives_q     <= lives_d;
         score_q     <= score_d;
         timer_q     <= timer_d;
         frog_anim_q <= (state_d != ST_OVER);
         dead_q      <= (state_d != ST_PLAY);
         obst_anim_q <= (state_d != ST_OVER);
         flash_q     <= (state_d == ST_DYING) & timer_d[3];
         over_q      <= (state_d == ST_OVER);
      end
   end

   assign bus.o_frog_animate = frog_anim_q;
   assign bus.o_dead         = dead_q;
   assign bus.o_obst_animate = obst_anim_q;
   assign bus.o_flash        = flash_q;
   assign bus.o_lives        = lives_q;
   assign bus.o_score        = score_q;
   assign bus.o_state        = state_q;
   assign bus.o_game_over    = over_q;
endmodule

// File: tb/tb_frog_game_ctrl.sv
// Directed bench for frog_game_ctrl: a strobe-by-strobe vector table plus
// hand-written start, reset and score-saturation sequences.
module tb_frog_game_ctrl;
   import frog_game_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   tests_run = 0;
   int   tests_failed = 0;

   always #5 clk = ~clk;

   frog_game_ctrl_if #(.LIVES_W(2), .SCORE_W(8)) bus_a ();
   frog_game_ctrl_if #(.LIVES_W(2), .SCORE_W(2)) bus_s ();

   frog_game_ctrl #(
      .LIVES(3), .LIVES_W(2), .SCORE_W(8), .TIMER_W(8),
      .DEATH_FRAMES(4), .WIN_FRAMES(2), .WIN_Y(20)
   ) dut_a (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_a)
   );

   frog_game_ctrl #(
      .LIVES(3), .LIVES_W(2), .SCORE_W(2), .TIMER_W(8),
      .DEATH_FRAMES(4), .WIN_FRAMES(2), .WIN_Y(20)
   ) dut_s (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_s)
   );

   typedef struct {
      logic        collide;
      logic [11:0] y1;
      logic [2:0]  st;
      logic [1:0]  lives;
      logic [7:0]  score;
   } vec_t;

   vec_t vecs[21];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One strobe after three idle clocks; returns on the negedge after the consuming edge.
   task automatic apply_stimulus(input bit sel, input logic c, input logic [11:0] y);
      repeat (3) @(negedge clk);
      if (sel) begin
         bus_s.i_ani_stb = 1'b1; bus_s.i_collide = c; bus_s.i_frog_y1 = y;
      end else begin
         bus_a.i_ani_stb = 1'b1; bus_a.i_collide = c; bus_a.i_frog_y1 = y;
      end
      @(negedge clk);
      bus_a.i_ani_stb = 1'b0; bus_a.i_collide = 1'b0; bus_a.i_frog_y1 = 12'd100;
      bus_s.i_ani_stb = 1'b0; bus_s.i_collide = 1'b0; bus_s.i_frog_y1 = 12'd100;
   endtask

   task automatic press_start(input bit sel);
      if (sel) bus_s.i_start_btn = 1'b1; else bus_a.i_start_btn = 1'b1;
      repeat (10) @(negedge clk);
      bus_a.i_start_btn = 1'b0;
      bus_s.i_start_btn = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic check_decode_a(input string tag, input logic [2:0] st);
      check_output({tag, " state"}, 32'(bus_a.o_state), 32'(st));
      check_output({tag, " dead"}, 32'(bus_a.o_dead), 32'(st != ST_CODE_PLAY));
      check_output({tag, " game_over"}, 32'(bus_a.o_game_over), 32'(st == ST_CODE_OVER));
      check_output({tag, " frog_animate"}, 32'(bus_a.o_frog_animate), 32'(st != ST_CODE_OVER));
      check_output({tag, " obst_animate"}, 32'(bus_a.o_obst_animate), 32'(st != ST_CODE_OVER));
      check_output({tag, " flash"}, 32'(bus_a.o_flash), 32'd0);
   endtask

   initial begin
      int entries;
      int lat;
      logic [2:0] prev_st;

      // Collision in GOAL is ignored, collision beats goal, three deaths end the game.
      vecs[0]  = '{1'b0, 12'd100, 3'd1, 2'd3, 8'd0};
      vecs[1]  = '{1'b0, 12'd20,  3'd3, 2'd3, 8'd1};
      vecs[2]  = '{1'b1, 12'd100, 3'd3, 2'd3, 8'd1};
      vecs[3]  = '{1'b0, 12'd100, 3'd1, 2'd3, 8'd1};
      vecs[4]  = '{1'b1, 12'd20,  3'd2, 2'd2, 8'd1};
      vecs[5]  = '{1'b1, 12'd100, 3'd2, 2'd2, 8'd1};
      vecs[6]  = '{1'b0, 12'd20,  3'd2, 2'd2, 8'd1};
      vecs[7]  = '{1'b0, 12'd100, 3'd2, 2'd2, 8'd1};
      vecs[8]  = '{1'b0, 12'd100, 3'd1, 2'd2, 8'd1};
      vecs[9]  = '{1'b0, 12'd21,  3'd1, 2'd2, 8'd1};
      vecs[10] = '{1'b1, 12'd100, 3'd2, 2'd1, 8'd1};
      vecs[11] = '{1'b0, 12'd100, 3'd2, 2'd1, 8'd1};
      vecs[12] = '{1'b0, 12'd100, 3'd2, 2'd1, 8'd1};
      vecs[13] = '{1'b0, 12'd100, 3'd2, 2'd1, 8'd1};
      vecs[14] = '{1'b0, 12'd100, 3'd1, 2'd1, 8'd1};
      vecs[15] = '{1'b1, 12'd100, 3'd2, 2'd0, 8'd1};
      vecs[16] = '{1'b0, 12'd100, 3'd2, 2'd0, 8'd1};
      vecs[17] = '{1'b0, 12'd100, 3'd2, 2'd0, 8'd1};
      vecs[18] = '{1'b0, 12'd100, 3'd2, 2'd0, 8'd1};
      vecs[19] = '{1'b0, 12'd100, 3'd4, 2'd0, 8'd1};
      vecs[20] = '{1'b1, 12'd20,  3'd4, 2'd0, 8'd1};

      rst_n = 1'b0;
      bus_a.i_ani_stb = 1'b0; bus_a.i_start_btn = 1'b0; bus_a.i_collide = 1'b0; bus_a.i_frog_y1 = 12'd100;
      bus_s.i_ani_stb = 1'b0; bus_s.i_start_btn = 1'b0; bus_s.i_collide = 1'b0; bus_s.i_frog_y1 = 12'd100;
      repeat (3) @(negedge clk);
      check_decode_a("reset", 3'd0);
      check_output("reset lives", 32'(bus_a.o_lives), 32'd3);
      check_output("reset score", 32'(bus_a.o_score), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_output("idle attract", 32'(bus_a.o_state), 32'd0);

      entries = 0;
      lat = -1;
      prev_st = bus_a.o_state;
      bus_a.i_start_btn = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (bus_a.o_state == ST_CODE_PLAY && prev_st != ST_CODE_PLAY) begin
            entries++;
            if (lat < 0) lat = k;
         end
         prev_st = bus_a.o_state;
         if (k == 10) bus_a.i_start_btn = 1'b0;
      end
      check_output("start entries", 32'(entries), 32'd1);
      check_output("start latency ok", 32'(lat >= 2 && lat <= 3), 32'd1);
      check_decode_a("after start", 3'd1);
      check_output("after start lives", 32'(bus_a.o_lives), 32'd3);

      for (int i = 0; i < 21; i++) begin
         apply_stimulus(1'b0, vecs[i].collide, vecs[i].y1);
         check_decode_a($sformatf("v%0d", i), vecs[i].st);
         check_output($sformatf("v%0d lives", i), 32'(bus_a.o_lives), 32'(vecs[i].lives));
         check_output($sformatf("v%0d score", i), 32'(bus_a.o_score), 32'(vecs[i].score));
      end

      press_start(1'b0);
      check_decode_a("restart", 3'd1);
      check_output("restart lives", 32'(bus_a.o_lives), 32'd3);
      check_output("restart score", 32'(bus_a.o_score), 32'd0);

      apply_stimulus(1'b0, 1'b0, 12'd5);
      check_output("pre-reset score", 32'(bus_a.o_score), 32'd1);
      apply_stimulus(1'b0, 1'b0, 12'd100);
      apply_stimulus(1'b0, 1'b0, 12'd100);
      check_output("pre-reset state", 32'(bus_a.o_state), 32'd1);
      rst_n = 1'b0;
      #1;
      check_output("async reset state", 32'(bus_a.o_state), 32'd0);
      check_output("async reset dead", 32'(bus_a.o_dead), 32'd1);
      check_output("async reset lives", 32'(bus_a.o_lives), 32'd3);
      check_output("async reset score", 32'(bus_a.o_score), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus(1'b0, 1'b0, 12'd20);
      repeat (16) @(negedge clk);
      check_output("post-reset attract", 32'(bus_a.o_state), 32'd0);
      check_output("post-reset dead", 32'(bus_a.o_dead), 32'd1);

      press_start(1'b1);
      check_output("sat start", 32'(bus_s.o_state), 32'd1);
      for (int g = 0; g < 5; g++) begin
         apply_stimulus(1'b1, 1'b0, 12'd20);
         check_output($sformatf("sat goal%0d state", g), 32'(bus_s.o_state), 32'd3);
         check_output($sformatf("sat goal%0d score", g), 32'(bus_s.o_score), (g >= 2) ? 32'd3 : 32'(g + 1));
         apply_stimulus(1'b1, 1'b0, 12'd100);
         apply_stimulus(1'b1, 1'b0, 12'd100);
         check_output($sformatf("sat goal%0d back", g), 32'(bus_s.o_state), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
